// File: rtl/ula_ctrl.sv
// rtl/ula_ctrl.sv - command FIFO and sequencer driving an 8-bit ALU over valid/ready
module ula_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic [CW-1:0]    count,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int EW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t         state, state_n;
    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [WW-1:0]  wcnt;
    logic [EW-1:0]  head;
    logic           push, pop, capture;

    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rptr];
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop     = 1'b1;
                state_n = WAIT;
            end
            WAIT: if (wcnt == '0) begin
                capture = 1'b1;
                state_n = HOLD;
            end
            HOLD: if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Storage needs no reset: count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {cmd_op, cmd_a, cmd_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            wcnt      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) begin
                rptr   <= rptr + AW'(1);
                alu_op <= head[EW-1 -: 3];
                res_op <= head[EW-1 -: 3];
                alu_a  <= head[2*WIDTH-1 -: WIDTH];
                alu_b  <= head[WIDTH-1:0];
                wcnt   <= WW'(LAT);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (state == WAIT && wcnt != '0) wcnt <= wcnt - WW'(1);
            if (capture) begin
                res_data  <= alu_s;
                res_valid <= 1'b1;
            end
            if (state == HOLD && res_ready) res_valid <= 1'b0;
        end
    end
endmodule

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
Operation sequencer acting as the initiator side of the 8-bit ALU (ula).
- Accepts operand/opcode commands on a valid/ready input, buffers them in a small FIFO and drives the ALU operand/opcode inputs one command at a time.
- Waits the ALU latency, captures the ALU result and presents it, tagged with its opcode, on a valid/ready output.
- Replaces hand-timed stimulus with a flow-controlled command path.

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
LAT, 1, ALU clock edges from operands applied to result valid; 0 means a combinational ALU.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
cmd_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A==B, 111 A!=B
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_op  output  3  registered opcode to ALU
alu_s  input  WIDTH  ALU result
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
res_op  output  3  opcode of captured result
count  output  clog2(DEPTH+1)  FIFO occupancy
busy  output  1  high when state != IDLE or count != 0

Behaviour:
- Reset: rst has priority over every other event, including mid-operation.
  - All outputs go to 0; FIFO is emptied; FSM goes to IDLE; wait counter is cleared.
  - In-flight and queued commands are dropped silently.
- Command FIFO:
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - cmd_ready is low whenever count == DEPTH, even if a pop happens in the same cycle. There is no full-bypass.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - A pop from an empty FIFO never occurs.
  - count is exact at all times.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, when count != 0: pop the head entry, load alu_a/alu_b/alu_op and res_op from it, set wcnt <= LAT, go to WAIT.
  - IDLE, when count == 0: stay; alu_* outputs hold their last values.
  - WAIT, when wcnt != 0: wcnt <= wcnt - 1.
  - WAIT, when wcnt == 0: res_data <= alu_s, res_valid <= 1, go to HOLD.
  - HOLD: res_valid, res_data and res_op are held stable. On an edge with res_ready high, res_valid <= 0 and the FSM goes to IDLE.
  - res_ready is ignored whenever res_valid is low.
- Timing:
  - Command accepted at edge E (FIFO previously empty, FSM IDLE): pop at E+1, capture at E+LAT+2, res_valid visible from cycle E+LAT+3.
  - Throughput is one command per LAT+3 cycles when res_ready is held high.
  - The FSM returns to IDLE on the accept edge, so the next pop happens one edge after the accept edge.
- Ordering: results are strictly in command order, one result per command.
- alu_* outputs stay constant from the pop edge until the next pop edge.
- res_data is passed through unmodified. Arithmetic is WIDTH-bit wrap-around as produced by the ALU (sub 5-10 = 0xFB). Compare results are 0 or 1 in the LSB.
- Backpressure: while in HOLD, the FIFO keeps accepting commands until full.

Test Plan:
- Reset, then cmd (a=5, b=10, op=000), res_ready=1 -> alu_a=5, alu_b=10 one cycle after pop. res_valid high exactly LAT+3 cycles after the accept edge, with res_data=0x0F, res_op=000. Pulse lasts one cycle.
- Back-to-back stream of ops 000..101 with a=5, b=10, res_ready=1 -> results in order: 0x0F, 0xFB, 0x00, 0x0F, 0x0F, 0xFA. Spacing is LAT+3 cycles. busy drops after the last accept.
- Compare ops: (8,8,110) -> 1; (5,10,110) -> 0; (8,8,111) -> 0; (5,10,111) -> 1.
- res_ready=0, push 6 cmds continuously -> first cmd enters HOLD, 4 cmds are buffered, count=4, cmd_ready=0, 6th cmd is stalled and not accepted. res_data stays stable during HOLD. Releasing res_ready drains all results in order; the 6th is accepted once count < 4.
- Assert rst during WAIT with 3 cmds queued -> next cycle: res_valid=0, count=0, busy=0, alu_*=0. No stale result appears afterward. A fresh cmd then completes normally.
- Wrap-around: 10 cmds with res_ready toggled randomly -> each result matches its command and no entry is lost or duplicated across pointer wrap.
